// File: rtl/debug_pkg.sv
// Shared definitions for the debug/trace slice: the run-control FSM state
// type and the default parameter values used by debug_trace_unit and
// trace_buffer.
package debug_pkg;

    // Run-control states. RUN executes freely, HALTED freezes the pipeline,
    // and STEP lets exactly one instruction issue before halting again.
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HALTED = 2'd1,
        STEP   = 2'd2
    } dbg_state_e;

    localparam int DEF_PC_W   = 32;
    localparam int DEF_DEPTH  = 16;
    localparam int DEF_NUM_BP = 2;

endpackage

// File: rtl/trace_buffer.sv
// Circular PC trace buffer. It keeps the most recent DEPTH issued PCs and
// overwrites the oldest entry when a write arrives while full; the sticky
// overflow flag records that this happened. clear flushes everything.
//
// Read handshake: rd_en is a request that is honoured only when the buffer
// holds at least one entry; the popped value is presented on rd_data with
// rd_valid high for exactly one cycle on the following clock. A request on
// an empty buffer is silently dropped and produces no rd_valid.
//
// Optional macro DEBUG_TRACE_MONITOR_EN: when defined, every accepted write
// is logged to the simulator console (time and PC in binary). Port
// behaviour is identical with or without it.
module trace_buffer
    import debug_pkg::*;
#(
    parameter int PC_W  = DEF_PC_W,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [PC_W-1:0]          wr_data,
    input  logic                     rd_en,
    input  logic                     clear,
    output logic [PC_W-1:0]          rd_data,
    output logic                     rd_valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [PC_W-1:0] mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            full;
    logic            empty;
    logic            do_rd;
    logic            do_wr;
    logic            overwrite;

    // Decode the operations that actually take effect this cycle; clear
    // suppresses both, and a read on empty is dropped.
    always_comb begin
        full      = (count == CW'(DEPTH));
        empty     = (count == '0);
        do_rd     = rd_en && !empty && !clear;
        do_wr     = wr_en && !clear;
        // A same-cycle pop frees a slot, so only a lone write overwrites.
        overwrite = do_wr && full && !do_rd;
    end

    // Pointers, occupancy, sticky overflow and the read-data register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else if (clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= do_rd;
            if (do_rd) begin
                rd_data <= mem[rd_ptr];
            end
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            // Overwrite discards the oldest entry by advancing the read side.
            if (do_rd || overwrite) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (overwrite) begin
                overflow <= 1'b1;
            end
            if (do_wr && !do_rd && !full) begin
                count <= count + 1'b1;
            end else if (do_rd && !do_wr) begin
                count <= count - 1'b1;
            end
        end
    end

    // Entry storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

`ifdef DEBUG_TRACE_MONITOR_EN
    // Simulation-only console log of each accepted write.
    always @(posedge clk) begin
        if (rst_n && do_wr) begin
            $display("[%0t] trace write pc=%b", $time, wr_data);
        end
    end
`endif

endmodule

// File: rtl/debug_trace_unit.sv
// Debug run-control plus PC trace. Breakpoint comparators and a halt
// request stop the pipeline (stall), resume/step release it, and every
// instruction that issues while not stalled is recorded in trace_buffer.
// The internal signal `state` is the FSM observation point for checkers.
//
// Optional macro DEBUG_TRACE_MONITOR_EN (forwarded to trace_buffer):
// console logging of trace writes, no effect on ports.
module debug_trace_unit
    import debug_pkg::*;
#(
    parameter int PC_W   = DEF_PC_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int NUM_BP = DEF_NUM_BP
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [PC_W-1:0]          pc_in,
    input  logic                     pc_valid,
    input  logic [NUM_BP*PC_W-1:0]   bp_addr,
    input  logic [NUM_BP-1:0]        bp_en,
    input  logic                     halt_req,
    input  logic                     resume,
    input  logic                     step,
    output logic                     stall,
    output logic                     halted,
    output logic [NUM_BP-1:0]        bp_hit,
    input  logic                     rd_en,
    output logic [PC_W-1:0]          rd_data,
    output logic                     rd_valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    input  logic                     clear
);

    dbg_state_e        state;
    dbg_state_e        state_next;
    logic [NUM_BP-1:0] match;
    logic              bp_any;
    logic              halted_q;
    logic              halted_next;
    logic [NUM_BP-1:0] bp_hit_next;
    logic              trace_wr;

    // Per-slot breakpoint comparators against the issuing PC.
    always_comb begin
        match = '0;
        for (int i = 0; i < NUM_BP; i++) begin
            match[i] = pc_valid && bp_en[i] && (pc_in == bp_addr[i*PC_W +: PC_W]);
        end
        bp_any = |match;
    end

    // State register; halted/stall and bp_hit are registered alongside it
    // from the next-state value so they change on the same edge as state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            halted_q <= 1'b0;
            bp_hit   <= '0;
        end else begin
            state    <= state_next;
            halted_q <= halted_next;
            bp_hit   <= bp_hit_next;
        end
    end

    // Next-state logic; resume wins over step, STEP skips breakpoints.
    always_comb begin
        state_next = state;
        unique case (state)
            RUN: begin
                if (bp_any || halt_req) begin
                    state_next = HALTED;
                end
            end
            HALTED: begin
                if (resume) begin
                    state_next = RUN;
                end else if (step) begin
                    state_next = STEP;
                end
            end
            STEP: begin
                if (pc_valid) begin
                    state_next = HALTED;
                end
            end
            default: state_next = RUN;
        endcase
    end

    // Output logic: next values for the registered halted flag and bp_hit.
    always_comb begin
        halted_next = (state_next == HALTED);
        bp_hit_next = bp_hit;
        case (state)
            RUN: begin
                if (bp_any) begin
                    bp_hit_next = match;
                end
            end
            HALTED: begin
                if (resume) begin
                    bp_hit_next = '0;
                end
            end
            default: bp_hit_next = bp_hit;
        endcase
    end

    assign stall    = halted_q;
    assign halted   = halted_q;
    // Only instructions that actually issue (pipeline not frozen) are traced.
    assign trace_wr = pc_valid && !halted_q;

    trace_buffer #(
        .PC_W  (PC_W),
        .DEPTH (DEPTH)
    ) u_trace_buffer (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (trace_wr),
        .wr_data  (pc_in),
        .rd_en    (rd_en),
        .clear    (clear),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .count    (count),
        .overflow (overflow)
    );

endmodule

// File: tb/tb_debug_trace_unit.sv
// Bench for debug_trace_unit (DEPTH=4 so wrap/overflow is reachable).
// A queue-based model of run control and the trace FIFO is checked against
// the DUT every cycle; directed literal checks pin the scenarios.
module tb_debug_trace_unit;

    localparam int PC_W   = 32;
    localparam int DEPTH  = 4;
    localparam int NUM_BP = 2;

    localparam int M_RUN    = 0;
    localparam int M_HALTED = 1;
    localparam int M_STEP   = 2;

    logic                    clk;
    logic                    rst_n;
    logic [PC_W-1:0]         pc_in;
    logic                    pc_valid;
    logic [NUM_BP*PC_W-1:0]  bp_addr;
    logic [NUM_BP-1:0]       bp_en;
    logic                    halt_req;
    logic                    resume;
    logic                    step;
    logic                    stall;
    logic                    halted;
    logic [NUM_BP-1:0]       bp_hit;
    logic                    rd_en;
    logic [PC_W-1:0]         rd_data;
    logic                    rd_valid;
    logic [$clog2(DEPTH):0]  count;
    logic                    overflow;
    logic                    clear;

    int checks = 0;
    int errors = 0;
    bit done = 0;

    debug_trace_unit #(
        .PC_W   (PC_W),
        .DEPTH  (DEPTH),
        .NUM_BP (NUM_BP)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pc_in    (pc_in),
        .pc_valid (pc_valid),
        .bp_addr  (bp_addr),
        .bp_en    (bp_en),
        .halt_req (halt_req),
        .resume   (resume),
        .step     (step),
        .stall    (stall),
        .halted   (halted),
        .bp_hit   (bp_hit),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .count    (count),
        .overflow (overflow),
        .clear    (clear)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    int                m_mode;
    logic [NUM_BP-1:0] m_hit;
    logic [PC_W-1:0]   exp_q[$];
    logic              m_ovf;
    logic              m_rd_valid;
    logic [PC_W-1:0]   m_rd_data;

    initial begin
        m_mode = M_RUN; m_hit = '0; m_ovf = 0; m_rd_valid = 0; m_rd_data = '0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_mode = M_RUN; m_hit = '0; m_ovf = 0;
                m_rd_valid = 0; m_rd_data = '0;
                exp_q.delete();
            end else begin
                logic issued;
                logic [NUM_BP-1:0] hits;
                issued = pc_valid && (m_mode != M_HALTED);
                hits = '0;
                for (int i = 0; i < NUM_BP; i++)
                    if (pc_valid && bp_en[i] && pc_in == bp_addr[i*PC_W +: PC_W]) hits[i] = 1'b1;
                // trace FIFO
                if (clear) begin
                    exp_q.delete();
                    m_ovf = 0;
                    m_rd_valid = 0;
                end else begin
                    m_rd_valid = 0;
                    if (rd_en && exp_q.size() > 0) begin
                        m_rd_data = exp_q.pop_front();
                        m_rd_valid = 1;
                    end
                    if (issued) begin
                        if (exp_q.size() == DEPTH) begin
                            void'(exp_q.pop_front());
                            m_ovf = 1;
                        end
                        exp_q.push_back(pc_in);
                    end
                end
                // run control
                if (m_mode == M_RUN) begin
                    if (hits != 0) begin m_mode = M_HALTED; m_hit = hits; end
                    else if (halt_req) m_mode = M_HALTED;
                end else if (m_mode == M_HALTED) begin
                    if (resume) begin m_mode = M_RUN; m_hit = '0; end
                    else if (step) m_mode = M_STEP;
                end else begin
                    if (pc_valid) m_mode = M_HALTED;
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (!done && rst_n) begin
                check("cyc_stall",    32'(stall),    32'(m_mode == M_HALTED));
                check("cyc_halted",   32'(halted),   32'(m_mode == M_HALTED));
                check("cyc_bp_hit",   32'(bp_hit),   32'(m_hit));
                check("cyc_count",    32'(count),    32'(exp_q.size()));
                check("cyc_overflow", 32'(overflow), 32'(m_ovf));
                check("cyc_rd_valid", 32'(rd_valid), 32'(m_rd_valid));
                check("cyc_rd_data",  32'(rd_data),  32'(m_rd_data));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic v, input logic [31:0] pc, input logic hr,
                         input logic rs, input logic st, input logic re, input logic cl);
        pc_valid = v; pc_in = pc; halt_req = hr; resume = rs; step = st; rd_en = re; clear = cl;
        @(posedge clk); #2;
        pc_valid = 0; halt_req = 0; resume = 0; step = 0; rd_en = 0; clear = 0;
    endtask

    task automatic issue(input logic [31:0] pc);
        drive(1, pc, 0, 0, 0, 0, 0);
    endtask

    task automatic pop();
        drive(0, 32'h0, 0, 0, 0, 1, 0);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        rst_n = 0; pc_valid = 0; pc_in = '0; halt_req = 0; resume = 0; step = 0;
        rd_en = 0; clear = 0;
        bp_en = 2'b01;
        bp_addr = {32'h0000_003C, 32'h0000_0040};   // slot1 (disabled) = 0x3C, slot0 = 0x40
        repeat (2) @(posedge clk);
        #2;
        check("rst_stall", 32'(stall), 0);
        check("rst_halted", 32'(halted), 0);
        check("rst_bp_hit", 32'(bp_hit), 0);
        check("rst_count", 32'(count), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_rd_valid", 32'(rd_valid), 0);
        check("rst_rd_data", rd_data, 0);
        rst_n = 1;

        // breakpoint halt; disabled slot1 must not fire on 0x3C
        issue(32'h3C);
        check("bp_pre_halted", 32'(halted), 0);
        issue(32'h40);
        check("bp_halted", 32'(halted), 1);
        check("bp_stall", 32'(stall), 1);
        check("bp_hit_slot0", 32'(bp_hit), 32'h1);
        check("bp_count", 32'(count), 2);
        issue(32'h44);
        check("halted_no_trace", 32'(count), 2);

        // single step
        drive(0, 0, 0, 0, 1, 0, 0);
        check("step_stall", 32'(stall), 0);
        issue(32'h44);
        check("step_rehalt", 32'(halted), 1);
        check("step_count", 32'(count), 3);
        check("step_hit_kept", 32'(bp_hit), 32'h1);

        // resume beats step
        drive(0, 0, 0, 1, 1, 0, 0);
        check("prio_halted", 32'(halted), 0);
        check("prio_bp_hit", 32'(bp_hit), 0);
        issue(32'h48);
        check("prio_run", 32'(halted), 0);
        check("full_count", 32'(count), 4);

        // full with simultaneous read and write
        drive(1, 32'h20, 0, 0, 0, 1, 0);
        check("rw_rd_valid", 32'(rd_valid), 1);
        check("rw_rd_data", rd_data, 32'h3C);
        check("rw_count", 32'(count), 4);
        check("rw_overflow", 32'(overflow), 0);

        // halt request, then clear while halted keeps FSM
        drive(0, 0, 1, 0, 0, 0, 0);
        check("hreq_halted", 32'(halted), 1);
        check("hreq_bp_hit", 32'(bp_hit), 0);
        drive(0, 0, 0, 0, 0, 1, 1);
        check("clr_count", 32'(count), 0);
        check("clr_rd_valid", 32'(rd_valid), 0);
        check("clr_fsm", 32'(halted), 1);
        drive(0, 0, 0, 1, 0, 0, 0);
        pop();
        check("empty_rd_valid", 32'(rd_valid), 0);
        check("empty_count", 32'(count), 0);
        drive(1, 32'h77, 0, 0, 0, 0, 1);
        check("clr_beats_wr", 32'(count), 0);

        // overflow: six writes into four slots
        for (int i = 0; i < 6; i++) issue(32'(i * 4));
        check("ovf_count", 32'(count), 4);
        check("ovf_flag", 32'(overflow), 1);
        for (int i = 0; i < 4; i++) begin
            pop();
            check("ovf_pop_valid", 32'(rd_valid), 1);
            check("ovf_pop_data", rd_data, 32'(8 + i * 4));
        end
        check("ovf_drained", 32'(count), 0);
        check("ovf_sticky", 32'(overflow), 1);

        // both slots enabled on the same address
        bp_en = 2'b11;
        bp_addr = {32'h80, 32'h80};
        issue(32'h80);
        check("bp_both_hit", 32'(bp_hit), 32'h3);
        check("bp_both_halted", 32'(halted), 1);
        drive(0, 0, 0, 1, 0, 0, 0);
        check("bp_both_resume", 32'(bp_hit), 0);

        // asynchronous reset while halted
        issue(32'h50);
        drive(0, 0, 1, 0, 0, 0, 0);
        check("pre_rst_halted", 32'(halted), 1);
        rst_n = 0;
        #1;
        check("arst_stall", 32'(stall), 0);
        check("arst_halted", 32'(halted), 0);
        check("arst_count", 32'(count), 0);
        check("arst_overflow", 32'(overflow), 0);
        @(posedge clk); #2;
        rst_n = 1;
        issue(32'h60);
        check("post_rst_run", 32'(halted), 0);
        check("post_rst_count", 32'(count), 1);

        repeat (2) @(posedge clk);
        #2;
        done = 1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/debug_trace_unit.md
DEBUG_TRACE_UNIT -- requirements
Module: debug_trace_unit

Interface
REQ-001 The block SHALL have parameter PC_W, default 32, giving the program-counter width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 16, giving trace-buffer entries; it SHALL be a power of two, minimum 2.
REQ-003 The block SHALL have parameter NUM_BP, default 2, giving the breakpoint comparator count, range 1..8.
REQ-004 The block SHALL have one clock and an asynchronous active-low reset; all ports are listed below with clock and reset first.
REQ-005 clk  in  1  rising-edge clock for all state.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 pc_in  in  PC_W  PC of the instruction presented this cycle.
REQ-008 pc_valid  in  1  pc_in is valid and the instruction issues this cycle.
REQ-009 bp_addr  in  NUM_BP*PC_W  breakpoint addresses, slot i at bits [i*PC_W +: PC_W].
REQ-010 bp_en  in  NUM_BP  per-slot breakpoint enable.
REQ-011 halt_req, resume, step  in  1 each  debugger command pulses.
REQ-012 stall  out  1  freezes the pipeline.
REQ-013 halted  out  1  FSM is in HALTED.
REQ-014 bp_hit  out  NUM_BP  slots that caused the last halt; sticky until resume.
REQ-015 rd_en  in  1  pop the oldest trace entry.
REQ-016 rd_data  out  PC_W  popped PC.
REQ-017 rd_valid  out  1  rd_data valid, one cycle.
REQ-018 count  out  $clog2(DEPTH)+1  number of entries held.
REQ-019 overflow  out  1  sticky flag: an entry was overwritten.
REQ-020 clear  in  1  synchronous flush of the buffer and overflow.

Function
REQ-021 The FSM SHALL have the states RUN, HALTED and STEP.
REQ-022 In RUN, pc_valid with pc_in equal to any enabled bp_addr SHALL cause a transition to HALTED at the next edge and SHALL latch the matching slots into bp_hit.
REQ-023 In RUN, halt_req SHALL cause a transition to HALTED at the next edge with bp_hit left unchanged.
REQ-024 stall SHALL equal halted, as a registered output with zero added latency after the state change.
REQ-025 In HALTED, resume SHALL cause a transition to RUN and clear bp_hit.
REQ-026 In HALTED, step SHALL cause a transition to STEP.
REQ-027 If resume and step are asserted in the same cycle, resume SHALL take priority.
REQ-028 In STEP, the first pc_valid SHALL return the FSM to HALTED without breakpoint evaluation.
REQ-029 Every pc_valid accepted while stall=0 SHALL write pc_in to the buffer tail.
REQ-030 On a write with count=DEPTH and no read, the oldest entry SHALL be overwritten, count SHALL stay at DEPTH, and overflow SHALL be set.
REQ-031 On rd_en with count>0, the buffer SHALL pop the oldest entry, and rd_data with rd_valid SHALL appear on the next cycle.
REQ-032 On rd_en with count=0, the buffer SHALL do nothing; rd_valid SHALL stay 0 and count SHALL not underflow.
REQ-033 On a simultaneous write and read, both operations SHALL be performed and count SHALL be unchanged; when full, no overwrite SHALL occur and overflow SHALL not be set.
REQ-034 Pointers SHALL wrap modulo DEPTH.
REQ-035 clear SHALL empty the buffer and clear overflow, SHALL take priority over a same-cycle write or read, and SHALL not affect the FSM.

Reset
REQ-036 While rst_n=0, state SHALL be RUN and stall, halted, bp_hit, rd_valid, count, overflow and the pointers SHALL all be 0.
REQ-037 rd_data SHALL reset to 0, and buffer storage SHALL need no reset.
REQ-038 Reset asserted mid-halt or mid-step SHALL return the FSM to RUN immediately, and stall SHALL deassert asynchronously.

Configuration
REQ-039 With DEBUG_TRACE_MONITOR_EN defined, each buffer write SHALL print the simulation time and the PC in binary via $display; the printing SHALL be non-synthesisable and have no effect on ports.
REQ-040 Without DEBUG_TRACE_MONITOR_EN, no display code SHALL be compiled, and port behaviour SHALL be identical.

Structure
REQ-041 The package debug_pkg SHALL hold the FSM state enum (RUN, HALTED, STEP) and the default parameter constants.
REQ-042 The circular buffer SHALL be a sub-module, trace_buffer, with parameters PC_W and DEPTH and its own pointers, count and overflow.

Verification
REQ-043 Breakpoint halt: bp_en=01, bp_addr[0]=0x40, with PCs 0x3C,0x40,0x44 -> halted=1 the cycle after 0x40, bp_hit=01, and trace count=2.
REQ-044 Single step: from HALTED, pulse step, then pc_valid with 0x44 -> stall=0 for one pc_valid, halted=1 again, and count increments by 1.
REQ-045 Overflow: with DEPTH=4, write 0x0,0x4,...,0x14 (6 PCs) -> count=4, overflow=1, and pops return 0x8,0xC,0x10,0x14.
REQ-046 Full plus simultaneous read/write: with count=4, rd_en with pc_valid 0x20 -> rd_data is the oldest entry, count=4, and overflow unchanged.
REQ-047 Reset mid-halt: halted=1, then rst_n=0 for 1 cycle -> stall=0 asynchronously, count=0, and state RUN.
REQ-048 Priority: resume and step in the same cycle -> RUN and bp_hit=0; pop on empty -> rd_valid=0 and count=0.
